// File: rtl/hazard_ctrl_pkg.sv
// Shared CPU definitions used by the hazard controller: FSM state type,
// register index width and the NOP instruction encoding.
package hazard_ctrl_pkg;

    localparam int unsigned CPU_REG_AW = 4;

    // Encoding loaded into a pipeline register when it is bubbled.
    localparam logic [15:0] NOP_INSN = 16'h0000;

    typedef enum logic {
        StRun,
        StMulti
    } hz_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; stops at all-ones.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         i_clk,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, multi-cycle execute sequencing,
// branch flush strobes and saturating stall/flush performance counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW       = CPU_REG_AW,
    parameter int unsigned MULTI_CYCLES = 4,
    parameter int unsigned PERF_W       = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_id_valid,
    input  logic [REG_AW-1:0] i_id_rs_a,
    input  logic [REG_AW-1:0] i_id_rs_b,
    input  logic              i_id_use_a,
    input  logic              i_id_use_b,
    input  logic              i_ex_valid,
    input  logic [REG_AW-1:0] i_ex_rd,
    input  logic              i_ex_mem_read,
    input  logic              i_ex_multi,
    input  logic              i_ex_flush,
    output logic              o_pc_stall,
    output logic              o_ifid_stall,
    output logic              o_idex_bubble,
    output logic              o_ex_hold,
    output logic              o_exmem_bubble,
    output logic              o_if_flush,
    output logic              o_id_flush,
    output logic              o_ex_done,
    output logic [PERF_W-1:0] o_stall_cnt,
    output logic [PERF_W-1:0] o_flush_cnt
);

    localparam int unsigned CNT_W = $clog2(MULTI_CYCLES);
    // The start cycle is spent in RUN, so the counter covers the rest.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULTI_CYCLES - 2);

    hz_state_e        r_state;
    hz_state_e        w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_next_cnt;
    logic             w_hit_a;
    logic             w_hit_b;
    logic             w_load_use;

    assign w_hit_a    = i_id_use_a && (i_id_rs_a == i_ex_rd);
    assign w_hit_b    = i_id_use_b && (i_id_rs_b == i_ex_rd);
    assign w_load_use = i_id_valid && i_ex_valid && i_ex_mem_read && (i_ex_rd != '0)
                        && (w_hit_a || w_hit_b);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StRun;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    always_comb begin
        w_next_state   = r_state;
        w_next_cnt     = r_cnt;
        o_pc_stall     = 1'b0;
        o_ifid_stall   = 1'b0;
        o_idex_bubble  = 1'b0;
        o_ex_hold      = 1'b0;
        o_exmem_bubble = 1'b0;
        o_if_flush     = 1'b0;
        o_id_flush     = 1'b0;
        o_ex_done      = 1'b0;

        unique case (r_state)
            StRun: begin
                if (i_ex_flush) begin
                    o_if_flush = 1'b1;
                    o_id_flush = 1'b1;
                end else if (i_ex_valid && i_ex_multi) begin
                    o_pc_stall     = 1'b1;
                    o_ifid_stall   = 1'b1;
                    o_ex_hold      = 1'b1;
                    o_exmem_bubble = 1'b1;
                    w_next_cnt     = CNT_LOAD;
                    w_next_state   = StMulti;
                end else if (w_load_use) begin
                    o_pc_stall    = 1'b1;
                    o_ifid_stall  = 1'b1;
                    o_idex_bubble = 1'b1;
                end
            end
            StMulti: begin
                o_pc_stall   = 1'b1;
                o_ifid_stall = 1'b1;
                o_ex_hold    = 1'b1;
                if (r_cnt != '0) begin
                    o_exmem_bubble = 1'b1;
                    w_next_cnt     = r_cnt - CNT_W'(1);
                end else begin
                    o_ex_done    = 1'b1;
                    w_next_state = StRun;
                end
            end
            default: begin
                w_next_state = StRun;
            end
        endcase

        // A reset cycle never stalls, flushes or completes anything.
        if (i_rst) begin
            o_pc_stall     = 1'b0;
            o_ifid_stall   = 1'b0;
            o_idex_bubble  = 1'b0;
            o_ex_hold      = 1'b0;
            o_exmem_bubble = 1'b0;
            o_if_flush     = 1'b0;
            o_id_flush     = 1'b0;
            o_ex_done      = 1'b0;
        end
    end

    sat_counter #(
        .W(PERF_W)
    ) u_stall_cnt (
        .i_clk(i_clk),
        .i_clr(i_rst),
        .i_inc(o_pc_stall),
        .o_cnt(o_stall_cnt)
    );

    sat_counter #(
        .W(PERF_W)
    ) u_flush_cnt (
        .i_clk(i_clk),
        .i_clr(i_rst),
        .i_inc(o_if_flush),
        .o_cnt(o_flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table, directed multi-cycle
// sequences and randomized traffic against a remaining-cycles reference model.
module tb_hazard_ctrl;

    localparam int unsigned MC   = 4;
    localparam int unsigned PW   = 4;
    localparam int          SMAX = (1 << PW) - 1;

    typedef struct packed {
        logic       id_valid;
        logic [3:0] rs_a;
        logic [3:0] rs_b;
        logic       use_a;
        logic       use_b;
        logic       ex_valid;
        logic [3:0] ex_rd;
        logic       mem_read;
        logic       multi;
        logic       flush;
    } in_t;

    typedef struct {
        string      name;
        in_t        in;
        logic [7:0] exp;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid, id_use_a, id_use_b, ex_valid, ex_mem_read, ex_multi, ex_flush;
    logic [3:0]    id_rs_a, id_rs_b, ex_rd;
    logic          pc_stall, ifid_stall, idex_bubble, ex_hold, exmem_bubble;
    logic          if_flush, id_flush, ex_done;
    logic [PW-1:0] stall_cnt, flush_cnt;
    logic [7:0]    dut_out;

    int         n_checks = 0;
    int         n_pass   = 0;
    int         m_busy   = 0;
    int         m_stall  = 0;
    int         m_flush  = 0;
    logic [7:0] last_out;
    vec_t       vecs[$];
    in_t        idle;

    always #5 clk = ~clk;

    assign dut_out = {pc_stall, ifid_stall, idex_bubble, ex_hold, exmem_bubble,
                      if_flush, id_flush, ex_done};

    hazard_ctrl #(
        .REG_AW(4),
        .MULTI_CYCLES(MC),
        .PERF_W(PW)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_id_valid(id_valid),
        .i_id_rs_a(id_rs_a),
        .i_id_rs_b(id_rs_b),
        .i_id_use_a(id_use_a),
        .i_id_use_b(id_use_b),
        .i_ex_valid(ex_valid),
        .i_ex_rd(ex_rd),
        .i_ex_mem_read(ex_mem_read),
        .i_ex_multi(ex_multi),
        .i_ex_flush(ex_flush),
        .o_pc_stall(pc_stall),
        .o_ifid_stall(ifid_stall),
        .o_idex_bubble(idex_bubble),
        .o_ex_hold(ex_hold),
        .o_exmem_bubble(exmem_bubble),
        .o_if_flush(if_flush),
        .o_id_flush(id_flush),
        .o_ex_done(ex_done),
        .o_stall_cnt(stall_cnt),
        .o_flush_cnt(flush_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic in_t mk(input logic idv, input int ra, input int rb, input logic ua,
                               input logic ub, input logic exv, input int rd, input logic mr,
                               input logic mu, input logic fl);
        in_t t;
        t.id_valid = idv;
        t.rs_a     = 4'(ra);
        t.rs_b     = 4'(rb);
        t.use_a    = ua;
        t.use_b    = ub;
        t.ex_valid = exv;
        t.ex_rd    = 4'(rd);
        t.mem_read = mr;
        t.multi    = mu;
        t.flush    = fl;
        return t;
    endfunction

    // Reference: m_busy is the number of stalled cycles still owed to a multi op.
    function automatic logic [7:0] model_out(input in_t t, input logic r);
        logic lu;
        lu = t.id_valid && t.ex_valid && t.mem_read && (t.ex_rd != 0) &&
             ((t.use_a && t.rs_a == t.ex_rd) || (t.use_b && t.rs_b == t.ex_rd));
        if (r) return 8'h00;
        if (m_busy > 0) return {4'b1101, m_busy > 1, 2'b00, m_busy == 1};
        if (t.flush) return 8'b0000_0110;
        if (t.ex_valid && t.multi) return 8'b1101_1000;
        if (lu) return 8'b1110_0000;
        return 8'h00;
    endfunction

    task automatic model_edge(input in_t t, input logic r, input logic [7:0] o);
        if (r) begin
            m_busy = 0; m_stall = 0; m_flush = 0;
        end else begin
            if (m_busy > 0) m_busy--;
            else if (!t.flush && t.ex_valid && t.multi) m_busy = MC - 1;
            if (o[7] && m_stall < SMAX) m_stall++;
            if (o[2] && m_flush < SMAX) m_flush++;
        end
    endtask

    // Drive one cycle at posedge+1, compare at posedge+3, advance model at the edge.
    task automatic step(input in_t t, input logic r, input string name);
        logic [7:0] exp;
        id_valid = t.id_valid; id_rs_a = t.rs_a; id_rs_b = t.rs_b;
        id_use_a = t.use_a; id_use_b = t.use_b; ex_valid = t.ex_valid; ex_rd = t.ex_rd;
        ex_mem_read = t.mem_read; ex_multi = t.multi; ex_flush = t.flush; rst = r;
        #2;
        exp = model_out(t, r);
        last_out = dut_out;
        check({name, "_out"}, {24'd0, dut_out}, {24'd0, exp});
        check({name, "_stall_cnt"}, {28'd0, stall_cnt}, 32'(m_stall));
        check({name, "_flush_cnt"}, {28'd0, flush_cnt}, 32'(m_flush));
        @(posedge clk);
        model_edge(t, r, exp);
        #1;
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 2 * MC && m_busy > 0; k++) step(idle, 1'b0, name);
    endtask

    initial begin
        in_t lu_a, mul;
        idle = '0;
        lu_a = mk(1, 3, 0, 1, 0, 1, 3, 1, 0, 0);
        mul  = mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 0);

        vecs.push_back('{"lu_rs_a",     lu_a,                                 8'b1110_0000});
        vecs.push_back('{"lu_rd_zero",  mk(1, 0, 0, 1, 0, 1, 0, 1, 0, 0), 8'b0000_0000});
        vecs.push_back('{"lu_unused_a", mk(1, 3, 0, 0, 0, 1, 3, 1, 0, 0), 8'b0000_0000});
        vecs.push_back('{"lu_rs_b",     mk(1, 1, 5, 0, 1, 1, 5, 1, 0, 0), 8'b1110_0000});
        vecs.push_back('{"lu_ex_inval", mk(1, 3, 0, 1, 0, 0, 3, 1, 0, 0), 8'b0000_0000});
        vecs.push_back('{"lu_id_inval", mk(0, 3, 0, 1, 0, 1, 3, 1, 0, 0), 8'b0000_0000});
        vecs.push_back('{"alu_no_lu",   mk(1, 3, 0, 1, 0, 1, 3, 0, 0, 0), 8'b0000_0000});
        vecs.push_back('{"flush_lu",    mk(1, 3, 0, 1, 0, 1, 3, 1, 0, 1), 8'b0000_0110});
        vecs.push_back('{"flush_multi", mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 1), 8'b0000_0110});
        vecs.push_back('{"multi_start", mul,                                  8'b1101_1000});
        vecs.push_back('{"multi_inval", mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), 8'b0000_0000});
        vecs.push_back('{"multi_vs_lu", mk(1, 3, 0, 1, 0, 1, 3, 1, 1, 0), 8'b1101_1000});

        rst = 1'b1;
        {id_valid, id_rs_a, id_rs_b, id_use_a, id_use_b} = '0;
        {ex_valid, ex_rd, ex_mem_read, ex_multi, ex_flush} = '0;
        @(posedge clk);
        #1;

        // Reset held with a multi op present: everything stays quiet.
        for (int i = 0; i < 3; i++) begin
            step(mul, 1'b1, "reset");
            check("reset_out_zero", {24'd0, last_out}, 32'd0);
        end
        check("reset_stall_cnt", {28'd0, stall_cnt}, 32'd0);
        check("reset_flush_cnt", {28'd0, flush_cnt}, 32'd0);
        step(idle, 1'b0, "idle_after_reset");

        foreach (vecs[i]) begin
            step(idle, 1'b1, "vec_reset");
            step(vecs[i].in, 1'b0, vecs[i].name);
            check({vecs[i].name, "_table"}, {24'd0, last_out}, {24'd0, vecs[i].exp});
            drain("vec_drain");
        end

        // Multi op with flush requests arriving while it is in MULTI.
        step(idle, 1'b1, "multi_reset");
        step(mul, 1'b0, "multi_c1");
        check("multi_c1_exp", {24'd0, last_out}, 32'hD8);
        step(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 1), 1'b0, "multi_c2_flush");
        check("multi_c2_exp", {24'd0, last_out}, 32'hD8);
        step(mk(1, 3, 0, 1, 0, 1, 3, 1, 1, 1), 1'b0, "multi_c3_flush_lu");
        check("multi_c3_exp", {24'd0, last_out}, 32'hD8);
        step(mul, 1'b0, "multi_c4");
        check("multi_c4_done", {24'd0, last_out}, 32'hD1);
        check("multi_stall_cnt4", {28'd0, stall_cnt}, 32'd4);
        check("multi_flush_cnt0", {28'd0, flush_cnt}, 32'd0);
        // Back-to-back: next op starts straight from RUN.
        step(mul, 1'b0, "b2b_start");
        check("b2b_start_exp", {24'd0, last_out}, 32'hD8);
        drain("b2b_drain");
        step(idle, 1'b0, "b2b_idle");
        check("b2b_idle_exp", {24'd0, last_out}, 32'h00);

        // Flush beats a simultaneous load-use.
        step(idle, 1'b1, "flush_reset");
        step(mk(1, 3, 0, 1, 0, 1, 3, 1, 0, 1), 1'b0, "flush_prio");
        check("flush_prio_exp", {24'd0, last_out}, 32'h06);
        check("flush_prio_cnt1", {28'd0, flush_cnt}, 32'd1);
        check("flush_prio_stall0", {28'd0, stall_cnt}, 32'd0);

        // Reset in the second cycle of a multi op.
        step(idle, 1'b1, "midrst_reset");
        step(mul, 1'b0, "midrst_c1");
        step(mul, 1'b1, "midrst_c2");
        check("midrst_c2_quiet", {24'd0, last_out}, 32'h00);
        step(idle, 1'b0, "midrst_after");
        check("midrst_no_done", {24'd0, last_out}, 32'h00);
        check("midrst_stall_cnt", {28'd0, stall_cnt}, 32'd0);

        // Saturation: 20 load-use stall cycles on a 4-bit counter.
        for (int i = 0; i < 20; i++) step(lu_a, 1'b0, "sat_lu");
        check("sat_stall_cnt15", {28'd0, stall_cnt}, 32'd15);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            in_t t;
            t.id_valid = 1'($urandom_range(0, 1));
            t.rs_a     = 4'($urandom_range(0, 3));
            t.rs_b     = 4'($urandom_range(0, 3));
            t.use_a    = 1'($urandom_range(0, 1));
            t.use_b    = 1'($urandom_range(0, 1));
            t.ex_valid = 1'($urandom_range(0, 3) != 0);
            t.ex_rd    = 4'($urandom_range(0, 3));
            t.mem_read = 1'($urandom_range(0, 1));
            t.multi    = ($urandom_range(0, 3) == 0);
            t.flush    = ($urandom_range(0, 7) == 0);
            step(t, $urandom_range(0, 40) == 0, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
